// File: rtl/uart_transmit_if.sv
// uart_transmit_if: byte handshake and serial line signals between a producer and the transmitter.
interface uart_transmit_if;
    logic       i_Tx_DataValid;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Ready;
    logic       o_Tx_Serial;
    logic       o_Tx_Active;
    logic       o_Tx_Done;
    modport master (
        output i_Tx_DataValid, i_Tx_Byte,
        input  o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done
    );
    modport slave (
        input  i_Tx_DataValid, i_Tx_Byte,
        output o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done
    );
endinterface

// File: rtl/uart_transmit.sv
// uart_transmit: 8N1 serial transmitter fed by a small byte FIFO.
module uart_transmit #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input logic           i_CLK,
    input logic           i_RST,
    uart_transmit_if.slave tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEAN} state_t;

    state_t        state_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [NW-1:0] count_q, count_d;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          line_q, active_q, done_q;
    logic          push, pop, baud_end;

    assign tx.o_Tx_Ready  = count_q != NW'(FIFO_DEPTH);
    assign tx.o_Tx_Serial = line_q;
    assign tx.o_Tx_Active = active_q;
    assign tx.o_Tx_Done   = done_q;

    assign push     = tx.i_Tx_DataValid && tx.o_Tx_Ready;
    assign pop      = (state_q == IDLE) && (count_q != '0);
    assign baud_end = baud_q == CW'(CLKS_PER_BIT - 1);

    always_comb count_d = count_q + NW'(push) - NW'(pop);

    always_ff @(posedge i_CLK)
        if (push) mem_q[wr_q] <= tx.i_Tx_Byte;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + PW'(push);
            rd_q    <= rd_q + PW'(pop);
            count_q <= count_d;
        end
    end

    // The next line level is registered on the same edge as each state change.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q  <= IDLE;
            line_q   <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (pop) begin
                        shift_q  <= mem_q[rd_q];
                        line_q   <= 1'b0;
                        active_q <= 1'b1;
                        baud_q   <= '0;
                        bit_q    <= '0;
                        state_q  <= START;
                    end else begin
                        line_q   <= 1'b1;
                        active_q <= 1'b0;
                    end
                end
                START: begin
                    baud_q <= baud_end ? '0 : baud_q + CW'(1);
                    if (baud_end) begin
                        line_q  <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    baud_q <= baud_end ? '0 : baud_q + CW'(1);
                    if (baud_end && bit_q == 3'd7) begin
                        line_q  <= 1'b1;
                        state_q <= STOP;
                    end else if (baud_end) begin
                        shift_q <= shift_q >> 1;
                        line_q  <= shift_q[1];
                        bit_q   <= bit_q + 3'd1;
                    end
                end
                STOP: begin
                    baud_q <= baud_end ? '0 : baud_q + CW'(1);
                    if (baud_end) begin
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= CLEAN;
                    end
                end
                CLEAN: begin
                    done_q  <= 1'b0;
                    line_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_transmit.sv
// tb_uart_transmit: randomized and directed checks of uart_transmit against a
// line decoder and a frame-timing model.
module tb_uart_transmit;
    localparam int CPB   = 217;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_transmit_if tif();

    uart_transmit #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_CLK(clk),
        .i_RST(rst),
        .tx   (tif)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tif.o_Tx_Done === 1'b1) done_cnt <= done_cnt + 1;
    end

    logic [7:0] rx_q[$];
    int         st_q[$];
    bit         fe_q[$];
    bit         mon_en = 1'b1;

    // Independent receiver: finds the start edge, samples every bit at mid-bit.
    initial begin : monitor
        logic       prev;
        logic [7:0] b;
        int         s;
        bit         ok;
        prev = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (mon_en && prev === 1'b1 && tif.o_Tx_Serial === 1'b0) begin
                s  = cyc;
                ok = 1'b1;
                repeat (CPB / 2) begin @(posedge clk); #2; end
                ok = ok && (tif.o_Tx_Serial === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(posedge clk); #2; end
                    b[i] = tif.o_Tx_Serial;
                end
                repeat (CPB) begin @(posedge clk); #2; end
                ok = ok && (tif.o_Tx_Serial === 1'b1);
                rx_q.push_back(b);
                st_q.push_back(s);
                fe_q.push_back(ok);
            end
            prev = tif.o_Tx_Serial;
        end
    end

    initial begin : watchdog
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 95000 cycles");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_q();
        rx_q.delete();
        st_q.delete();
        fe_q.delete();
    endtask

    task automatic push_byte(input logic [7:0] b, input bit hold, output int acc);
        int budget;
        budget = 3 * FRAME;
        tif.i_Tx_Byte      = b;
        tif.i_Tx_DataValid = 1'b1;
        while (tif.o_Tx_Ready !== 1'b1 && budget > 0) begin step(); budget--; end
        if (budget == 0) begin
            checks++; errors++;
            $display("FAIL push_ready: ready=%b required 1 within %0d cycles", tif.o_Tx_Ready, 3 * FRAME);
        end
        step();
        acc = cyc;
        if (!hold) tif.i_Tx_DataValid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int budget;
        budget = (n + 2) * (FRAME + 2);
        while (rx_q.size() < n && budget > 0) begin step(); budget--; end
    endtask

    task automatic test_reset();
        tif.i_Tx_DataValid = 1'b0;
        tif.i_Tx_Byte      = 8'h00;
        rst = 1'b1;
        step(3);
        checks++;
        if ({tif.o_Tx_Serial, tif.o_Tx_Active, tif.o_Tx_Done, tif.o_Tx_Ready} !== 4'b1001)
            begin errors++; $display("FAIL reset_outputs: serial/active/done/ready=%b%b%b%b required 1001",
                tif.o_Tx_Serial, tif.o_Tx_Active, tif.o_Tx_Done, tif.o_Tx_Ready); end
        rst = 1'b0;
        step(2);
        checks++;
        if ({tif.o_Tx_Serial, tif.o_Tx_Active, tif.o_Tx_Ready} !== 3'b101)
            begin errors++; $display("FAIL post_reset_idle: serial/active/ready=%b%b%b required 101",
                tif.o_Tx_Serial, tif.o_Tx_Active, tif.o_Tx_Ready); end
    endtask

    task automatic test_frame();
        logic [7:0] v;
        logic       e;
        int         acc, bad, d0;
        v = 8'hA5; bad = 0; d0 = done_cnt;
        clear_q();
        push_byte(v, 1'b0, acc);
        checks++;
        if (tif.o_Tx_Serial !== 1'b1)
            begin errors++; $display("FAIL frame_not_early: serial=%b required 1 on accept edge", tif.o_Tx_Serial); end
        step();
        for (int c = 0; c < FRAME; c++) begin
            e = (c < CPB) ? 1'b0 : (c < 9 * CPB) ? v[c / CPB - 1] : 1'b1;
            if (tif.o_Tx_Serial !== e || tif.o_Tx_Active !== 1'b1 || tif.o_Tx_Done !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL frame_waveform: %0d bad cycles required 0", bad); end
        checks++;
        if ({tif.o_Tx_Done, tif.o_Tx_Active, tif.o_Tx_Serial} !== 3'b101)
            begin errors++; $display("FAIL frame_end: done/active/serial=%b%b%b required 101",
                tif.o_Tx_Done, tif.o_Tx_Active, tif.o_Tx_Serial); end
        step();
        checks++;
        if ({tif.o_Tx_Done, tif.o_Tx_Serial} !== 2'b01)
            begin errors++; $display("FAIL done_pulse_width: done/serial=%b%b required 01", tif.o_Tx_Done, tif.o_Tx_Serial); end
        wait_rx(1);
        step(2);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== v || !fe_q[0] || st_q[0] != acc + 1 || done_cnt - d0 != 1)
            begin errors++; $display("FAIL frame_decode: n=%0d byte=%h start=%0d dones=%0d required n=1 byte=%h start=%0d dones=1",
                rx_q.size(), rx_q.size() ? rx_q[0] : 8'hxx, st_q.size() ? st_q[0] : -1, done_cnt - d0, v, acc + 1); end
        step(CPB);
    endtask

    task automatic test_loopback();
        logic [7:0] v[3];
        int         acc, d0;
        v = '{8'h00, 8'hFF, 8'h5A};
        d0 = done_cnt;
        clear_q();
        for (int i = 0; i < 3; i++) push_byte(v[i], 1'b0, acc);
        wait_rx(3);
        step(CPB);
        checks++;
        if (rx_q.size() != 3) begin errors++; $display("FAIL loop_count: got %0d bytes required 3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== v[i] || !fe_q[i])
                begin errors++; $display("FAIL loop_byte%0d: got %h framing=%0d required %h", i, rx_q[i], fe_q[i], v[i]); end
        end
        checks++;
        if (done_cnt - d0 != 3) begin errors++; $display("FAIL loop_dones: got %0d required 3", done_cnt - d0); end
    endtask

    // Held valid: five bytes go in on consecutive edges (the first is popped at
    // once), then the full FIFO refuses until the second frame's pop frees a slot.
    task automatic test_burst();
        int acc[6];
        clear_q();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                checks++;
                if (tif.o_Tx_Ready !== 1'b0)
                    begin errors++; $display("FAIL burst_full: ready=%b required 0", tif.o_Tx_Ready); end
            end
            push_byte(8'(i + 1), i < 5, acc[i]);
        end
        checks++;
        if (acc[4] - acc[0] != 4) begin errors++; $display("FAIL burst_accept: span %0d required 4", acc[4] - acc[0]); end
        wait_rx(6);
        step(CPB);
        checks++;
        if (rx_q.size() != 6) begin errors++; $display("FAIL burst_count: got %0d required 6", rx_q.size()); end
        else begin
            checks++;
            if (st_q[0] != acc[0] + 1)
                begin errors++; $display("FAIL burst_first_start: got %0d required %0d", st_q[0], acc[0] + 1); end
            checks++;
            if (acc[5] != st_q[1] + 1)
                begin errors++; $display("FAIL full_push_refused: accept %0d required %0d", acc[5], st_q[1] + 1); end
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (rx_q[i] !== 8'(i + 1) || !fe_q[i])
                    begin errors++; $display("FAIL burst_byte%0d: got %h required %h", i, rx_q[i], 8'(i + 1)); end
                if (i > 0) begin
                    checks++;
                    if (st_q[i] - st_q[i - 1] != FRAME + 2)
                        begin errors++; $display("FAIL burst_gap%0d: got %0d required %0d", i, st_q[i] - st_q[i - 1], FRAME + 2); end
                end
            end
        end
    endtask

    task automatic test_simul_push_pop();
        logic [7:0] v[6];
        int         a, p, bad;
        v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        bad = 0;
        clear_q();
        push_byte(v[0], 1'b0, a);
        push_byte(v[1], 1'b0, p);
        push_byte(v[2], 1'b0, p);
        p = a + 1 + FRAME + 2;
        while (cyc < p - 1) step();
        for (int i = 3; i < 6; i++) begin
            tif.i_Tx_Byte      = v[i];
            tif.i_Tx_DataValid = 1'b1;
            if (tif.o_Tx_Ready !== 1'b1) bad++;
            step();
        end
        tif.i_Tx_DataValid = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL simul_ready: %0d refusals required 0", bad); end
        checks++;
        if (tif.o_Tx_Ready !== 1'b0)
            begin errors++; $display("FAIL simul_count: ready=%b after two extra pushes required 0", tif.o_Tx_Ready); end
        wait_rx(6);
        step(CPB);
        checks++;
        if (rx_q.size() != 6 || st_q[1] != p)
            begin errors++; $display("FAIL simul_frames: n=%0d second start=%0d required n=6 start=%0d",
                rx_q.size(), st_q.size() > 1 ? st_q[1] : -1, p); end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== v[i] || !fe_q[i])
                begin errors++; $display("FAIL simul_byte%0d: got %h required %h", i, rx_q[i], v[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        int a, b, d0, bad;
        bad = 0;
        mon_en = 1'b0;
        clear_q();
        push_byte(8'hC3, 1'b0, a);
        push_byte(8'h99, 1'b0, b);
        while (cyc < a + 1 + 4 * CPB + CPB / 2) step();
        checks++;
        if (tif.o_Tx_Serial !== 1'b0 || tif.o_Tx_Active !== 1'b1)
            begin errors++; $display("FAIL mid_bit3: serial/active=%b%b required 01", tif.o_Tx_Serial, tif.o_Tx_Active); end
        d0 = done_cnt;
        rst = 1'b1;
        step();
        checks++;
        if ({tif.o_Tx_Serial, tif.o_Tx_Active, tif.o_Tx_Ready, tif.o_Tx_Done} !== 4'b1010)
            begin errors++; $display("FAIL abort: serial/active/ready/done=%b%b%b%b required 1010",
                tif.o_Tx_Serial, tif.o_Tx_Active, tif.o_Tx_Ready, tif.o_Tx_Done); end
        rst = 1'b0;
        for (int c = 0; c < FRAME + CPB; c++) begin
            step();
            if (tif.o_Tx_Serial !== 1'b1 || tif.o_Tx_Active !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || done_cnt != d0)
            begin errors++; $display("FAIL abort_quiet: %0d busy cycles, %0d dones required 0 and 0", bad, done_cnt - d0); end
        mon_en = 1'b1;
        step();
        push_byte(8'h3C, 1'b0, a);
        wait_rx(1);
        step(CPB);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h3C || !fe_q[0])
            begin errors++; $display("FAIL after_abort: n=%0d byte=%h required n=1 byte=3c",
                rx_q.size(), rx_q.size() ? rx_q[0] : 8'hxx); end
    endtask

    task automatic test_idle();
        int d0, bad;
        d0 = done_cnt; bad = 0;
        clear_q();
        repeat (5000) begin
            step();
            if (tif.o_Tx_Serial !== 1'b1 || tif.o_Tx_Active !== 1'b0 || tif.o_Tx_Done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || done_cnt != d0 || rx_q.size() != 0)
            begin errors++; $display("FAIL idle: %0d bad cycles, %0d dones, %0d frames required 0",
                bad, done_cnt - d0, rx_q.size()); end
    endtask

    // Start of frame i is the later of (accept + 1) and (previous start + FRAME + 2).
    task automatic test_random();
        logic [7:0] v[4];
        int         acc[4];
        int         exp_st;
        clear_q();
        for (int i = 0; i < 4; i++) begin
            step($urandom_range(0, FRAME));
            v[i] = 8'($urandom);
            push_byte(v[i], 1'b0, acc[i]);
        end
        wait_rx(4);
        step(CPB);
        checks++;
        if (rx_q.size() != 4) begin errors++; $display("FAIL rand_count: got %0d required 4", rx_q.size()); end
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            exp_st = (i == 0) ? acc[0] + 1 :
                     (acc[i] + 1 > st_q[i - 1] + FRAME + 2) ? acc[i] + 1 : st_q[i - 1] + FRAME + 2;
            checks++;
            if (rx_q[i] !== v[i] || !fe_q[i] || st_q[i] != exp_st)
                begin errors++; $display("FAIL rand%0d: byte=%h start=%0d required byte=%h start=%0d",
                    i, rx_q[i], st_q[i], v[i], exp_st); end
        end
    endtask

    initial begin
        tif.i_Tx_DataValid = 1'b0;
        tif.i_Tx_Byte      = 8'h00;
        test_reset();
        test_frame();
        test_loopback();
        test_burst();
        test_simul_push_pop();
        test_reset_midframe();
        test_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
